// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one AXIMaster command port among three requesters.
// Serves one transaction at a time and releases a stuck owner via a completion watchdog.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [2:0]              Req,
    input  logic [2:0]              ReqWrite,
    input  logic [3*ADDR_WIDTH-1:0] ReqAddr,
    output logic [2:0]              Grant,
    output logic [2:0]              Done,
    output logic [2:0]              Error,
    output logic [ADDR_WIDTH-1:0]   AXIAddr,
    output logic                    StartAXIRead,
    output logic                    StartAXIWrite,
    input  logic                    AXIReadCompleted,
    input  logic                    AXIWriteCompleted,
    output logic                    Busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t        state;
    logic [1:0]    sel;
    logic [1:0]    last;
    logic          wr;
    logic [TW-1:0] timer;
    logic [1:0]    pick;
    logic          completed;

    // First set request bit searching upward from the slot after the last served one.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] prev);
        logic [1:0] idx;
        rr_pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(prev) + k) % 3);
            if (req[idx])
                rr_pick = idx;
        end
    endfunction

    always_comb begin
        pick      = rr_pick(Req, last);
        completed = wr ? AXIWriteCompleted : AXIReadCompleted;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            sel           <= 2'd0;
            last          <= 2'd2;
            wr            <= 1'b0;
            timer         <= '0;
            Grant         <= 3'b000;
            Done          <= 3'b000;
            Error         <= 3'b000;
            AXIAddr       <= '0;
            StartAXIRead  <= 1'b0;
            StartAXIWrite <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            StartAXIRead  <= 1'b0;
            StartAXIWrite <= 1'b0;
            Done          <= 3'b000;
            Error         <= 3'b000;
            case (state)
                IDLE: begin
                    if (|Req) begin
                        // Start pulse is registered here so it is visible during ISSUE.
                        sel           <= pick;
                        wr            <= ReqWrite[pick];
                        AXIAddr       <= ReqAddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        Grant         <= 3'b001 << pick;
                        StartAXIWrite <= ReqWrite[pick];
                        StartAXIRead  <= ~ReqWrite[pick];
                        Busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (completed) begin
                        Done  <= Grant;
                        state <= RELEASE;
                    end else if (TIMEOUT_CYCLES != 0 && timer == TIMER_LAST) begin
                        Error <= Grant;
                        state <= RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    Grant <= 3'b000;
                    last  <= sel;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
